ysyx_25040111_load_unit: RTL

Sequential load unit for the NPC LSU stage, successor to the combinational load decoder. It accepts one load per transaction and issues aligned reads on a valid/ready memory read channel. It extracts, zero- or sign-extends and returns the result with a writeback handshake. It is parametrised in XLEN (RV32/RV64 loads) and optionally splits beat-crossing misaligned loads into two bus beats.

---
 rtl/ysyx_25040111_load_unit_pkg.sv | 46 ++++
 rtl/ysyx_25040111_load_unit_if.sv | 29 ++
 rtl/ysyx_25040111_load_align.sv | 47 ++++
 rtl/ysyx_25040111_load_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_load_unit_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_load_unit_pkg
// Shared definitions for the sequential load unit:
//   - RISC-V load funct3 encodings
//   - exception codes reported on out_exc
//   - FSM state encoding
//   - funct3 legality helper (RV64-only loads gated by rv64)
// No ports; imported by the load unit top.
// ---------------------------------------------------------------------------
package ysyx_25040111_load_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_ACCESS   = 2'd1;
    localparam logic [1:0] EXC_MISALIGN = 2'd2;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR0  = 3'd1,
        ST_R0   = 3'd2,
        ST_AR1  = 3'd3,
        ST_R1   = 3'd4,
        ST_RESP = 3'd5
    } state_e;

    // ld and lwu only exist on a 64-bit datapath.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic rv64);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            F3_LD, F3_LWU:                       ok = rv64;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ysyx_25040111_load_unit_if.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_load_unit_if
// Memory read channel between the load unit (master) and memory (slave).
//   ar_valid/ar_ready/ar_addr : beat-aligned read address handshake
//   r_valid/r_ready/r_data    : little-endian beat data handshake
//   r_err                     : access fault for the returned beat
// Parameter XLEN sets address and data width (32 or 64).
// ---------------------------------------------------------------------------
interface ysyx_25040111_load_unit_if #(
    parameter int XLEN = 32
);
    logic            ar_valid;
    logic            ar_ready;
    logic [XLEN-1:0] ar_addr;
    logic            r_valid;
    logic            r_ready;
    logic [XLEN-1:0] r_data;
    logic            r_err;

    modport master (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data, r_err
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data, r_err
    );
endinterface

// File: rtl/ysyx_25040111_load_align.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_load_align
// Combinational load result extraction.
//   beat1, beat0 : two consecutive bus beats (beat0 = lower address)
//   off          : byte offset of the load within beat0
//   funct3       : load type; [1:0] size, [2] zero-extend
//   result       : ({beat1, beat0} >> off*8) truncated to size, extended
// ---------------------------------------------------------------------------
module ysyx_25040111_load_align #(
    parameter  int XLEN  = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  beat1,
    input  logic [XLEN-1:0]  beat0,
    input  logic [OFF_W-1:0] off,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  result
);

    logic [XLEN-1:0] window;
    int              nbits;

    // Keep bits [nbits-1:0] of v and fill the rest with zero or the sign bit.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input int nbits_i,
                                               input logic zext);
        logic [XLEN-1:0] r;
        logic            fill;
        fill = zext ? 1'b0 : v[nbits_i-1];
        for (int i = 0; i < XLEN; i++) begin
            r[i] = (i < nbits_i) ? v[i] : fill;
        end
        return r;
    endfunction

    always_comb begin
        window = XLEN'({beat1, beat0} >> {off, 3'b000});
        nbits  = 8 << funct3[1:0];
        // A 64-bit size on a 32-bit datapath is an illegal load whose result
        // is discarded; clamp so the extension never indexes past the window.
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        result = extend(window, nbits, funct3[2]);
    end

endmodule

// File: rtl/ysyx_25040111_load_unit.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_load_unit
// Sequential LSU load unit: accepts one load, issues aligned reads on the
// memory read channel, extends the loaded value and returns it with a
// writeback handshake. One transaction in flight at a time.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   load request handshake
//   in_funct3/in_addr/in_rd  load type, byte address, destination register
//   mem                 memory read channel (master modport)
//   out_valid/out_ready writeback handshake
//   out_data            extended result (0 when out_exc != 0)
//   out_rd              destination register of the returned load
//   out_exc             0 none, 1 access fault, 2 misaligned, 3 illegal
//
// Configuration macro YSYX_25040111_MISALIGN_SPLIT_EN:
//   defined   - misaligned loads are served; beat-crossing loads take two
//               beats through AR1/R1
//   undefined - every misaligned load returns exc 2 without bus traffic
// ---------------------------------------------------------------------------
module ysyx_25040111_load_unit
    import ysyx_25040111_load_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_funct3,
    input  logic [XLEN-1:0]           in_addr,
    input  logic [4:0]                in_rd,
    ysyx_25040111_load_unit_if.master mem,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_data,
    output logic [4:0]                out_rd,
    output logic [1:0]                out_exc
);

    localparam int   BEAT_B = XLEN / 8;
    localparam int   OFF_W  = $clog2(BEAT_B);
    localparam logic RV64   = (XLEN == 64);
`ifdef YSYX_25040111_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [1:0]      exc_q, exc_d;

    logic [2:0]      funct3_p0;
    logic [XLEN-1:0] addr_p0;
    logic [4:0]      rd_p0;
    logic [XLEN-1:0] beat0_p1;
    logic [XLEN-1:0] beat1_w;
`ifdef YSYX_25040111_MISALIGN_SPLIT_EN
    logic [XLEN-1:0] beat1_p1;
    logic            cross_p0;
    logic            cap1;
`endif

    logic            req_fire;
    logic            cap0;
    logic            in_mis;
    logic [OFF_W-1:0] off_p0;
    logic [XLEN-1:0] base_addr;
    logic [XLEN-1:0] align_data;

    // Misalignment of the incoming request against its natural size.
    always_comb begin
        in_mis = 1'b0;
        case (in_funct3[1:0])
            2'd1:    in_mis = in_addr[0];
            2'd2:    in_mis = |in_addr[1:0];
            2'd3:    in_mis = |in_addr[2:0];
            default: in_mis = 1'b0;
        endcase
    end

    assign off_p0    = addr_p0[OFF_W-1:0];
    assign base_addr = {addr_p0[XLEN-1:OFF_W], {OFF_W{1'b0}}};

`ifdef YSYX_25040111_MISALIGN_SPLIT_EN
    assign cross_p0 = (int'(off_p0) + (1 << funct3_p0[1:0])) > BEAT_B;
`endif

    assign req_fire = (state_q == ST_IDLE) && in_valid;
    assign cap0     = (state_q == ST_R0) && mem.r_valid;
`ifdef YSYX_25040111_MISALIGN_SPLIT_EN
    assign cap1     = (state_q == ST_R1) && mem.r_valid;
`endif

    // Next-state and exception tracking.
    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!funct3_legal(in_funct3, RV64)) begin
                        exc_d   = EXC_ILLEGAL;
                        state_d = ST_RESP;
                    end else if (in_mis && !SPLIT_EN) begin
                        exc_d   = EXC_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        exc_d   = EXC_NONE;
                        state_d = ST_AR0;
                    end
                end
            end
            ST_AR0: begin
                if (mem.ar_ready) begin
                    state_d = ST_R0;
                end
            end
            ST_R0: begin
                if (mem.r_valid) begin
                    // A faulting first beat ends the load without a second read.
                    if (mem.r_err) begin
                        exc_d   = EXC_ACCESS;
                        state_d = ST_RESP;
                    end
`ifdef YSYX_25040111_MISALIGN_SPLIT_EN
                    else if (cross_p0) begin
                        state_d = ST_AR1;
                    end
`endif
                    else begin
                        state_d = ST_RESP;
                    end
                end
            end
`ifdef YSYX_25040111_MISALIGN_SPLIT_EN
            ST_AR1: begin
                if (mem.ar_ready) begin
                    state_d = ST_R1;
                end
            end
            ST_R1: begin
                if (mem.r_valid) begin
                    if (mem.r_err) begin
                        exc_d = EXC_ACCESS;
                    end
                    state_d = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    // Stage p0: request latched on acceptance
    always_ff @(posedge clk) begin
        if (req_fire) begin
            funct3_p0 <= in_funct3;
            addr_p0   <= in_addr;
            rd_p0     <= in_rd;
        end
    end

    // Stage p1: returned beats captured
    always_ff @(posedge clk) begin
        if (cap0) begin
            beat0_p1 <= mem.r_data;
        end
`ifdef YSYX_25040111_MISALIGN_SPLIT_EN
        if (cap1) begin
            beat1_p1 <= mem.r_data;
        end
`endif
    end

`ifdef YSYX_25040111_MISALIGN_SPLIT_EN
    assign beat1_w = beat1_p1;
`else
    assign beat1_w = '0;
`endif

    ysyx_25040111_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .beat1  (beat1_w),
        .beat0  (beat0_p1),
        .off    (off_p0),
        .funct3 (funct3_p0),
        .result (align_data)
    );

    // Outputs decode registered state only; everything reads 0 in reset.
    assign in_ready     = rst_n && (state_q == ST_IDLE);
    assign mem.ar_valid = (state_q == ST_AR0) || (state_q == ST_AR1);
    assign mem.ar_addr  = (state_q == ST_AR0) ? base_addr :
                          (state_q == ST_AR1) ? base_addr + XLEN'(BEAT_B) : '0;
    assign mem.r_ready  = (state_q == ST_R0) || (state_q == ST_R1);
    assign out_valid    = (state_q == ST_RESP);
    assign out_rd       = (state_q == ST_RESP) ? rd_p0 : 5'd0;
    assign out_exc      = (state_q == ST_RESP) ? exc_q : EXC_NONE;
    assign out_data     = ((state_q == ST_RESP) && (exc_q == EXC_NONE)) ? align_data : '0;

endmodule
